axi4_lite_arbiter: RTL and testbench
====================================

# axi4_lite_arbiter

Two-master to one-slave AXI4-Lite arbiter sitting between the instruction fetch unit (read-only master), the load/store unit (read/write master) and the single memory-side AXI4-Lite slave port of the NPC SoC. It grants the slave to one transaction at a time. Selection is round-robin between IFU and LSU. The block forwards the granted master's channels combinationally and returns to idle once the response handshake completes. One transaction is outstanding at most; no reordering, no buffering of data.

## Interface
- `SIMULATION` (define, default undefined): when defined, enables the 64-bit performance counters `perf_grant_ifu`, `perf_grant_lsu` and `perf_conflict`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ifu_araddr` in 32, `ifu_arvalid` in 1, `ifu_arready` out 1: IFU read-address channel.
- `ifu_rdata` out 32, `ifu_rresp` out 2, `ifu_rvalid` out 1, `ifu_rready` in 1: IFU read-data channel.
- `lsu_araddr` in 32, `lsu_arvalid` in 1, `lsu_arready` out 1: LSU read-address channel.
- `lsu_rdata` out 32, `lsu_rresp` out 2, `lsu_rvalid` out 1, `lsu_rready` in 1: LSU read-data channel.
- `lsu_awaddr` in 32, `lsu_awvalid` in 1, `lsu_awready` out 1: LSU write-address channel.
- `lsu_wdata` in 32, `lsu_wstrb` in 4, `lsu_wvalid` in 1, `lsu_wready` out 1: LSU write-data channel.
- `lsu_bresp` out 2, `lsu_bvalid` out 1, `lsu_bready` in 1: LSU write-response channel.
- `s_araddr` out 32, `s_arvalid` out 1, `s_arready` in 1: slave read-address channel.
- `s_rdata` in 32, `s_rresp` in 2, `s_rvalid` in 1, `s_rready` out 1: slave read-data channel.
- `s_awaddr` out 32, `s_awvalid` out 1, `s_awready` in 1: slave write-address channel.
- `s_wdata` out 32, `s_wstrb` out 4, `s_wvalid` out 1, `s_wready` in 1: slave write-data channel.
- `s_bresp` in 2, `s_bvalid` in 1, `s_bready` out 1: slave write-response channel.

## Operation
- **States:** IDLE, IFU_RD, LSU_RD, LSU_WR. Registered state plus `last_lsu` (1 = LSU was granted last), `ar_done`, `aw_done`, `w_done`.
- **Requests sampled in IDLE:**
  - `req_ifu` = `ifu_arvalid`.
  - `req_lsu_wr` = `lsu_awvalid | lsu_wvalid`.
  - `req_lsu_rd` = `lsu_arvalid`.
- **LSU internal priority:** write over read.
- **Grant when both IFU and LSU request:** IFU if `last_lsu` = 1, else LSU.
- **Grant when only one requests:** that requester.
- **Grant update:** on grant, `last_lsu` <= (grant is LSU), and all done flags are cleared.
- **Forwarding in IFU_RD / LSU_RD:**
  - `s_ar*` <= granted master's AR. `s_arvalid` = master arvalid & ~`ar_done`.
  - Master arready = `s_arready` & ~`ar_done`.
  - `s_rready` = master rready. Master rvalid/rdata/rresp = slave values.
- **Forwarding in LSU_WR:** AW and W are forwarded the same way, gated by `aw_done` / `w_done`. B is forwarded to the LSU.
- **Done flags:** set on the respective handshake (valid & ready) and held until the next grant.
- **Completion:**
  - IFU_RD/LSU_RD -> IDLE on `s_rvalid & s_rready`.
  - LSU_WR -> IDLE on `s_bvalid & s_bready`.
- **Non-granted master and all channels in IDLE:** every ready/valid output is 0. Data outputs are driven 0 when not forwarded.
- **Responses:** `rresp`/`bresp` (including SLVERR/DECERR) are passed through unmodified. The arbiter never retries.
- **Performance counters (SIMULATION only):**
  - `perf_grant_ifu` / `perf_grant_lsu` increment on each grant.
  - `perf_conflict` increments on each IDLE cycle where IFU and LSU both request.

## Timing
- **Reset:**
  - State = IDLE, `last_lsu` = 1 (IFU wins the first conflict), done flags = 0.
  - All slave-side valids, master-side readies, master-side valids and all data outputs are 0.
  - Performance counters = 0.
- **Arbitration latency:** 1 cycle. A request visible in IDLE at edge t is forwarded from cycle t+1. Masters must hold valid (AXI rule).
- **Minimum read:** arbiter grants at t, AR handshake at t+1, R handshake at t+2, IDLE at t+3.
- **Back-to-back:** a new grant is sampled at t+3, so there is 1 idle cycle between consecutive transactions.
- **Write channel ordering:** AW and W may complete in either order or in the same cycle. B is accepted even if it arrives the same cycle as the last of AW/W.
- **Reset mid-transaction:** immediately returns to IDLE with all outputs at reset values. The in-flight slave response is dropped.
- **Requests during a transaction:** ignored until IDLE; the requesting master sees ready = 0.

## Test plan
- IFU read alone, slave 1-cycle: `ifu_araddr`=0x80000000 → `s_araddr`=0x80000000 at t+1, `ifu_rdata`=slave 0x00000413 at t+2, state IDLE at t+3.
- IFU and LSU read in the same cycle after reset → IFU granted first, LSU second. Repeat the conflict → grants alternate LSU, IFU.
- LSU write with W valid 2 cycles before AW: `wdata`=0xDEADBEEF, `wstrb`=0xF, addr 0x80001000 → `s_wvalid` drops after the W handshake, `lsu_bvalid` is forwarded, no duplicate W.
- LSU write and read both pending, IFU idle → write serviced before read.
- Slave returns `rresp`=2'b10 to the LSU → `lsu_rresp`=2'b10, no retry, next request granted normally.
- `rst` asserted while in LSU_WR after AW, before B → all outputs 0 in the same cycle. After release, an IFU request is granted with 1-cycle latency.

Source files
------------

// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: round-robin IFU/LSU arbiter onto one AXI4-Lite slave, one transaction at a time
module axi4_lite_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  input  logic [31:0] lsu_araddr,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  input  logic [31:0] lsu_awaddr,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);
  localparam logic [1:0] IDLE = 2'd0, IFU_RD = 2'd1, LSU_RD = 2'd2, LSU_WR = 2'd3;
  logic [1:0] state_q, state_d;
  logic last_lsu_q, last_lsu_d, ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic idle, in_ifu, in_lsu_rd, in_wr, req_ifu, req_lsu_wr, req_lsu, gnt_ifu, gnt_lsu, gnt;
  always_comb begin
    idle        = state_q == IDLE;
    in_ifu      = state_q == IFU_RD;
    in_lsu_rd   = state_q == LSU_RD;
    in_wr       = state_q == LSU_WR;
    req_ifu     = ifu_arvalid;
    req_lsu_wr  = lsu_awvalid | lsu_wvalid;
    req_lsu     = req_lsu_wr | lsu_arvalid;
    gnt_ifu     = idle & req_ifu & (~req_lsu | last_lsu_q);
    gnt_lsu     = idle & req_lsu & ~gnt_ifu;
    gnt         = gnt_ifu | gnt_lsu;
    s_araddr    = in_ifu ? ifu_araddr : in_lsu_rd ? lsu_araddr : 32'd0;
    s_arvalid   = ((in_ifu & ifu_arvalid) | (in_lsu_rd & lsu_arvalid)) & ~ar_done_q;
    ifu_arready = in_ifu & s_arready & ~ar_done_q;
    lsu_arready = in_lsu_rd & s_arready & ~ar_done_q;
    s_rready    = (in_ifu & ifu_rready) | (in_lsu_rd & lsu_rready);
    ifu_rvalid  = in_ifu & s_rvalid;
    ifu_rdata   = in_ifu ? s_rdata : 32'd0;
    ifu_rresp   = in_ifu ? s_rresp : 2'd0;
    lsu_rvalid  = in_lsu_rd & s_rvalid;
    lsu_rdata   = in_lsu_rd ? s_rdata : 32'd0;
    lsu_rresp   = in_lsu_rd ? s_rresp : 2'd0;
    s_awaddr    = in_wr ? lsu_awaddr : 32'd0;
    s_awvalid   = in_wr & lsu_awvalid & ~aw_done_q;
    lsu_awready = in_wr & s_awready & ~aw_done_q;
    s_wdata     = in_wr ? lsu_wdata : 32'd0;
    s_wstrb     = in_wr ? lsu_wstrb : 4'd0;
    s_wvalid    = in_wr & lsu_wvalid & ~w_done_q;
    lsu_wready  = in_wr & s_wready & ~w_done_q;
    s_bready    = in_wr & lsu_bready;
    lsu_bvalid  = in_wr & s_bvalid;
    lsu_bresp   = in_wr ? s_bresp : 2'd0;
    state_d     = idle ? (gnt_ifu ? IFU_RD : gnt_lsu ? (req_lsu_wr ? LSU_WR : LSU_RD) : IDLE)
                : ((in_ifu | in_lsu_rd) & s_rvalid & s_rready) | (in_wr & s_bvalid & s_bready) ? IDLE
                : state_q;
    last_lsu_d  = gnt ? gnt_lsu : last_lsu_q;
    ar_done_d   = ~gnt & (ar_done_q | (s_arvalid & s_arready));
    aw_done_d   = ~gnt & (aw_done_q | (s_awvalid & s_awready));
    w_done_d    = ~gnt & (w_done_q | (s_wvalid & s_wready));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b1;
      ar_done_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      ar_done_q  <= ar_done_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end
`ifdef SIMULATION
  logic [63:0] perf_grant_ifu, perf_grant_lsu, perf_conflict;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_ifu <= 64'd0;
      perf_grant_lsu <= 64'd0;
      perf_conflict  <= 64'd0;
    end else begin
      perf_grant_ifu <= perf_grant_ifu + {63'd0, gnt_ifu};
      perf_grant_lsu <= perf_grant_lsu + {63'd0, gnt_lsu};
      perf_conflict  <= perf_conflict + {63'd0, idle & req_ifu & req_lsu};
    end
  end
`endif
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb_axi4_lite_arbiter: directed checks of grant order, forwarding, done gating and reset
module tb_axi4_lite_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, s_rdata;
  logic ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready;
  logic [3:0] lsu_wstrb;
  logic s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [1:0] s_rresp, s_bresp;
  logic ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
  logic [31:0] ifu_rdata, lsu_rdata, s_araddr, s_awaddr, s_wdata;
  logic [1:0] ifu_rresp, lsu_rresp, lsu_bresp;
  logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [3:0] s_wstrb;
  logic [181:0] outs;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign outs = {ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, lsu_arready, lsu_rvalid, lsu_rdata,
                 lsu_rresp, lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid, s_araddr, s_arvalid,
                 s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};
  axi4_lite_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );
  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  // entered one cycle after the grant; leaves at the negedge of the following idle cycle
  task automatic rd_txn(input bit lsu, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    chk("ar_addr", s_araddr, addr);
    chk("ar_valid", s_arvalid, 1);
    chk("ar_ready", {ifu_arready, lsu_arready}, lsu ? 2'b01 : 2'b10);
    cyc();
    chk("ar_done", {s_arvalid, ifu_arready, lsu_arready}, 0);
    if (lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    s_rvalid = 1'b1;
    s_rdata = data;
    s_rresp = resp;
    #1;
    chk("r_valid", {ifu_rvalid, lsu_rvalid, s_rready}, lsu ? 3'b011 : 3'b101);
    chk("r_data", lsu ? {lsu_rdata, lsu_rresp} : {ifu_rdata, ifu_rresp}, {data, resp});
    chk("r_other", lsu ? {ifu_rdata, ifu_rresp} : {lsu_rdata, lsu_rresp}, 0);
    cyc();
    chk("rd_idle", outs, 0);
    s_rvalid = 1'b0;
    s_rdata = 32'd0;
    s_rresp = 2'd0;
  endtask
  initial begin
    ifu_araddr = 32'hFFFF_FFFF; ifu_arvalid = 1; ifu_rready = 1;
    lsu_araddr = 32'hFFFF_FFFF; lsu_arvalid = 1; lsu_rready = 1;
    lsu_awaddr = 32'hFFFF_FFFF; lsu_awvalid = 1; lsu_wdata = 32'hFFFF_FFFF; lsu_wstrb = 4'hF;
    lsu_wvalid = 1; lsu_bready = 1;
    s_arready = 1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b11; s_rvalid = 1;
    s_awready = 1; s_wready = 1; s_bresp = 2'b11; s_bvalid = 1;
    @(negedge clk);
    chk("reset_outs", outs, 0);
    ifu_araddr = 0; ifu_arvalid = 0; lsu_araddr = 0; lsu_arvalid = 0;
    lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0;
    s_rdata = 0; s_rresp = 0; s_rvalid = 0; s_bresp = 0; s_bvalid = 0;
    @(negedge clk);
    rst = 1'b0;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
    #1 chk("grant_latency", {ifu_arready, s_arvalid}, 0);
    cyc();
    rd_txn(0, 32'h8000_0000, 32'h0000_0413, 2'b00);
    do_reset();
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0004;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_2000;
    #1 chk("conflict_latency", {ifu_arready, lsu_arready}, 0);
    cyc();
    rd_txn(0, 32'h8000_0004, 32'h1111_1111, 2'b00);
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0008;
    cyc();
    rd_txn(1, 32'h8000_2000, 32'h2222_2222, 2'b00);
    lsu_arvalid = 1; lsu_araddr = 32'h8000_2004;
    cyc();
    rd_txn(0, 32'h8000_0008, 32'h3333_3333, 2'b00);
    cyc();
    rd_txn(1, 32'h8000_2004, 32'h4444_4444, 2'b01);
    lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    #1 chk("w_latency", s_wvalid, 0);
    cyc();
    chk("w_fwd", {s_wvalid, s_wdata, s_wstrb, lsu_wready}, {1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1});
    chk("aw_absent", {s_awvalid, s_awaddr}, 0);
    cyc();
    chk("w_no_dup", {s_wvalid, lsu_wready}, 0);
    lsu_wvalid = 0; lsu_awvalid = 1; lsu_awaddr = 32'h8000_1000;
    #1 chk("aw_fwd", {s_awvalid, s_awaddr, lsu_awready}, {1'b1, 32'h8000_1000, 1'b1});
    cyc();
    chk("aw_done", {s_awvalid, lsu_awready}, 0);
    lsu_awvalid = 0; s_bvalid = 1; s_bresp = 2'b00;
    #1 chk("b_fwd", {lsu_bvalid, lsu_bresp, s_bready, s_wvalid}, {1'b1, 2'b00, 1'b1, 1'b0});
    cyc();
    chk("wr_idle", outs, 0);
    s_bvalid = 0;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_3000;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_1004; lsu_wvalid = 1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3;
    cyc();
    chk("wr_before_rd", {s_awvalid, s_wvalid, s_arvalid, lsu_arready}, 4'b1100);
    chk("wr_payload", {s_awaddr, s_wdata, s_wstrb}, {32'h8000_1004, 32'h1234_5678, 4'h3});
    cyc();
    lsu_awvalid = 0; lsu_wvalid = 0; s_bvalid = 1; s_bresp = 2'b11;
    #1 chk("bresp_pass", {lsu_bvalid, lsu_bresp}, 3'b111);
    cyc();
    chk("wr2_idle", outs, 0);
    s_bvalid = 0; s_bresp = 0;
    cyc();
    rd_txn(1, 32'h8000_3000, 32'hCAFE_F00D, 2'b10);
    cyc();
    chk("no_retry", outs, 0);
    ifu_arvalid = 1; ifu_araddr = 32'h8000_000C;
    cyc();
    rd_txn(0, 32'h8000_000C, 32'h5555_5555, 2'b00);
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_1008; lsu_wvalid = 1; lsu_wdata = 32'hA5A5_A5A5;
    lsu_wstrb = 4'h1; s_wready = 0;
    cyc();
    chk("aw_fwd2", {s_awvalid, s_awaddr}, {1'b1, 32'h8000_1008});
    chk("w_stall", {s_wvalid, lsu_wready}, 2'b10);
    cyc();
    lsu_awvalid = 0; s_wready = 1; s_bvalid = 1;
    #1 chk("pre_rst", {s_awvalid, s_wvalid, lsu_wready, lsu_bvalid}, 4'b0111);
    rst = 1'b1;
    #1 chk("rst_mid", outs, 0);
    @(negedge clk);
    chk("rst_hold", outs, 0);
    rst = 1'b0; lsu_wvalid = 0; s_bvalid = 0;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0010;
    #1 chk("post_rst_latency", ifu_arready, 0);
    cyc();
    rd_txn(0, 32'h8000_0010, 32'h6666_6666, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
